// File: rtl/ghash_digit_engine_if.sv
// Handshake bundle between GCM block steering, the GHASH engine and the tag stage.
interface ghash_digit_engine_if;
    logic [127:0] h_in;
    logic         h_load;
    logic [127:0] in_blk;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] tag_out;
    logic         tag_valid;
    logic         tag_ready;
    logic         busy;

    modport master (
        output h_in, h_load, in_blk, in_valid, in_last, tag_ready,
        input  in_ready, tag_out, tag_valid, busy
    );

    modport slave (
        input  h_in, h_load, in_blk, in_valid, in_last, tag_ready,
        output in_ready, tag_out, tag_valid, busy
    );
endinterface

// File: rtl/ghash_digit_engine.sv
// GHASH accumulator: Y = (Y ^ X) * H in GF(2^128), DIGIT_BITS multiplicand bits per cycle.
module ghash_digit_engine #(
    parameter int DIGIT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    ghash_digit_engine_if.slave  bus
);
    localparam int BLK_BITS = 128;
    localparam int NDIG     = BLK_BITS / DIGIT_BITS;
    localparam int CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]       LAST_CNT = CW'(NDIG - 1);
    localparam logic [BLK_BITS-1:0] R_POLY   = {8'he1, 120'd0};

    generate
        if (DIGIT_BITS != 1  && DIGIT_BITS != 2  && DIGIT_BITS != 4 &&
            DIGIT_BITS != 8  && DIGIT_BITS != 16 && DIGIT_BITS != 32 &&
            DIGIT_BITS != 64 && DIGIT_BITS != 128) begin : g_bad_digit
            $error("DIGIT_BITS must be a power of two from 1 to 128");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_TAG} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BLK_BITS-1:0] r_h;
    logic [BLK_BITS-1:0] r_y;
    logic [BLK_BITS-1:0] r_x;
    logic [BLK_BITS-1:0] r_z;
    logic [BLK_BITS-1:0] r_v;
    logic [BLK_BITS-1:0] r_tag;
    logic [CW-1:0]       r_cnt;
    logic                r_last;
    logic [BLK_BITS-1:0] w_z;
    logic [BLK_BITS-1:0] w_v;
    logic                w_accept;
    logic                w_final;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_final  = (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.h_load) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_accept)      w_state_nxt = S_MULT;
                S_MULT: if (w_final)       w_state_nxt = r_last ? S_TAG : S_IDLE;
                S_TAG:  if (bus.tag_ready) w_state_nxt = S_IDLE;
                default:                   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE) && !bus.h_load;
        bus.tag_valid = (r_state == S_TAG);
        bus.busy      = (r_state != S_IDLE);
        bus.tag_out   = r_tag;
    end

    // X is shifted left each digit, so the current digit always sits in the top bits.
    always_comb begin
        w_z = r_z;
        w_v = r_v;
        for (int k = 0; k < DIGIT_BITS; k++) begin
            if (r_x[BLK_BITS-1-k]) w_z = w_z ^ w_v;
            w_v = w_v[0] ? ((w_v >> 1) ^ R_POLY) : (w_v >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h    <= '0;
            r_y    <= '0;
            r_x    <= '0;
            r_z    <= '0;
            r_v    <= '0;
            r_tag  <= '0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (bus.h_load) begin
            r_h   <= bus.h_in;
            r_y   <= '0;
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x    <= r_y ^ bus.in_blk;
                        r_z    <= '0;
                        r_v    <= r_h;
                        r_last <= bus.in_last;
                        r_cnt  <= '0;
                    end
                end
                S_MULT: begin
                    r_z <= w_z;
                    r_v <= w_v;
                    r_x <= r_x << DIGIT_BITS;
                    if (w_final) begin
                        r_cnt <= '0;
                        r_y   <= w_z;
                        if (r_last) r_tag <= w_z;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TAG: begin
                    if (bus.tag_ready) r_y <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ghash_digit_engine.sv
// Scoreboard bench for ghash_digit_engine with GCM test vectors.
module tb_ghash_digit_engine;
    localparam int D    = 8;
    localparam int NDIG = 128 / D;

    localparam logic [127:0] H_K0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] ONE   = 128'h80000000000000000000000000000000;
    localparam logic [127:0] C1    = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] LEN   = 128'h00000000000000000000000000000080;
    localparam logic [127:0] Y1    = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] T2    = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam logic [127:0] H_ALT = 128'h0123456789abcdeffedcba9876543210;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ghash_digit_engine_if u_if ();
    ghash_digit_engine_if u_if1 ();
    ghash_digit_engine_if u_if128 ();

    assign u_if1.h_in       = u_if.h_in;
    assign u_if1.h_load     = u_if.h_load;
    assign u_if1.in_blk     = u_if.in_blk;
    assign u_if1.in_valid   = u_if.in_valid;
    assign u_if1.in_last    = u_if.in_last;
    assign u_if1.tag_ready  = u_if.tag_ready;
    assign u_if128.h_in      = u_if.h_in;
    assign u_if128.h_load    = u_if.h_load;
    assign u_if128.in_blk    = u_if.in_blk;
    assign u_if128.in_valid  = u_if.in_valid;
    assign u_if128.in_last   = u_if.in_last;
    assign u_if128.tag_ready = u_if.tag_ready;

    ghash_digit_engine #(.DIGIT_BITS(D))   dut    (.clk(clk), .reset(reset), .bus(u_if));
    ghash_digit_engine #(.DIGIT_BITS(1))   dut1   (.clk(clk), .reset(reset), .bus(u_if1));
    ghash_digit_engine #(.DIGIT_BITS(128)) dut128 (.clk(clk), .reset(reset), .bus(u_if128));

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [127:0] blk, input logic last, input logic [127:0] tag);
        int n;
        @(negedge clk);
        u_if.in_blk   = blk;
        u_if.in_last  = last;
        u_if.in_valid = 1'b1;
        if (last) exp_q.push_back(tag);
        n = 0;
        while (!u_if.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (u_if.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_tag(input string tag);
        int n;
        n = 0;
        while (!u_if.tag_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk({tag, "_timeout"}, 128'd0, 128'd1);
        if (exp_q.size() == 0) chk({tag, "_noexp"}, 128'd0, 128'd1);
        else chk(tag, u_if.tag_out, exp_q.pop_front());
    endtask

    task automatic ack();
        u_if.tag_ready = 1'b1;
        @(negedge clk);
        u_if.tag_ready = 1'b0;
    endtask

    task automatic hload(input logic [127:0] h);
        @(negedge clk);
        u_if.h_in   = h;
        u_if.h_load = 1'b1;
        @(negedge clk);
        u_if.h_load = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n, l8, l1, l128;
        reset          = 1'b1;
        u_if.h_in      = '0;
        u_if.h_load    = 1'b0;
        u_if.in_blk    = '0;
        u_if.in_valid  = 1'b0;
        u_if.in_last   = 1'b0;
        u_if.tag_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(u_if.in_ready), 128'd1);
        chk("rst_tag_valid", 128'(u_if.tag_valid), 128'd0);
        chk("rst_busy", 128'(u_if.busy), 128'd0);
        chk("rst_tag_out", u_if.tag_out, 128'd0);

        // identity multiply on all three digit widths, with latency
        hload(H_K0);
        @(negedge clk);
        u_if.in_blk   = ONE;
        u_if.in_last  = 1'b1;
        u_if.in_valid = 1'b1;
        exp_q.push_back(H_K0);
        @(posedge clk);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        n = 1; l8 = 0; l1 = 0; l128 = 0;
        while ((l8 == 0 || l1 == 0 || l128 == 0) && n < 300) begin
            if (u_if.tag_valid    && l8   == 0) l8   = n;
            if (u_if1.tag_valid   && l1   == 0) l1   = n;
            if (u_if128.tag_valid && l128 == 0) l128 = n;
            if (l8 == 0 || l1 == 0 || l128 == 0) begin
                @(negedge clk);
                n++;
            end
        end
        chk("lat_d8", 128'(l8), 128'(NDIG + 1));
        chk("lat_d1", 128'(l1), 128'd129);
        chk("lat_d128", 128'(l128), 128'd2);
        chk("id_d1", u_if1.tag_out, H_K0);
        chk("id_d128", u_if128.tag_out, H_K0);
        wait_tag("id_d8");
        ack();
        chk("ack_tag_valid", 128'(u_if.tag_valid), 128'd0);
        chk("ack_hold_tag", u_if.tag_out, H_K0);

        // GCM test case 2
        send(C1, 1'b0, '0);
        wait_idle();
        chk("tc2_y1", dut.r_y, Y1);
        send(LEN, 1'b1, T2);
        wait_tag("tc2_tag");
        ack();

        // back-to-back repeat with stalled consumer
        send(C1, 1'b0, '0);
        send(LEN, 1'b1, T2);
        wait_tag("b2b_tag");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 128'(u_if.tag_valid), 128'd1);
            chk("stall_tag", u_if.tag_out, T2);
            chk("stall_ready", 128'(u_if.in_ready), 128'd0);
        end
        ack();

        // zero inputs
        send('0, 1'b0, '0);
        send('0, 1'b1, '0);
        wait_tag("zero_tag");
        ack();
        hload(H_ALT);
        send('0, 1'b1, '0);
        wait_tag("zero_alt_h");
        ack();

        // h_load mid-multiply
        hload(H_K0);
        send(C1, 1'b0, '0);
        repeat (NDIG / 2) @(negedge clk);
        chk("mid_cnt", 128'(dut.r_cnt), 128'(NDIG / 2));
        u_if.h_in   = H_K0;
        u_if.h_load = 1'b1;
        @(negedge clk);
        u_if.h_load = 1'b0;
        chk("abort_busy", 128'(u_if.busy), 128'd0);
        chk("abort_valid", 128'(u_if.tag_valid), 128'd0);
        chk("abort_y", dut.r_y, 128'd0);
        send(C1, 1'b0, '0);
        send(LEN, 1'b1, T2);
        wait_tag("replay_tag");
        ack();

        // reset while tag pending
        send(C1, 1'b0, '0);
        send(LEN, 1'b1, T2);
        wait_tag("pre_reset_tag");
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tag_valid2", 128'(u_if.tag_valid), 128'd0);
        chk("rst_tag_out2", u_if.tag_out, 128'd0);
        chk("rst_in_ready2", 128'(u_if.in_ready), 128'd1);
        chk("rst_busy2", 128'(u_if.busy), 128'd0);
        reset = 1'b0;
        chk("sb_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
